// File: rtl/panel_scan.sv
// rtl/panel_scan.sv - frame scanner: requests every pixel from a layer, blends it over the background, writes the framebuffer
// One request/response per pixel in raster order, then a single animation tick per frame.
module panel_scan #(
  parameter int          WIDTH    = 64,
  parameter int          HEIGHT   = 32,
  parameter int          ADDR_W   = 11,
  parameter int          TIMEOUT  = 15,
  parameter logic [23:0] BG_COLOR = 24'h000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_layer_ready,
  output logic              o_layer_valid,
  output logic              o_layer_tick,
  output logic [9:0]        o_layer_x,
  output logic [9:0]        o_layer_y,
  input  logic              i_pix_valid,
  input  logic [7:0]        i_pix_r,
  input  logic [7:0]        i_pix_g,
  input  logic [7:0]        i_pix_b,
  input  logic [7:0]        i_pix_a,
  output logic              o_pix_ack,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [23:0]       o_wr_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout_err,
  output logic [15:0]       o_frame_count
);

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WRITE, S_TICK} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [TO_W-1:0]   r_to_cnt;
  logic [23:0]       r_wr_data;
  logic              r_done;
  logic              r_timeout_err;
  logic [15:0]       r_frame_count;
  logic              w_last_x;
  logic              w_last_y;
  logic              w_timeout;

  // (c*a + b*(255-a) + 255) >> 8 never exceeds 65280, so 16 bits suffice.
  function automatic logic [7:0] blend_ch(input logic [7:0] c, input logic [7:0] b,
                                          input logic [7:0] a);
    logic [15:0] sum;
    sum = 16'(c) * 16'(a) + 16'(b) * 16'(8'd255 - a) + 16'd255;
    return sum[15:8];
  endfunction

  function automatic logic [23:0] blend_rgb(input logic [31:0] rgba);
    return {blend_ch(rgba[31:24], BG_COLOR[23:16], rgba[7:0]),
            blend_ch(rgba[23:16], BG_COLOR[15:8],  rgba[7:0]),
            blend_ch(rgba[15:8],  BG_COLOR[7:0],   rgba[7:0])};
  endfunction

  assign w_last_x  = (r_x == 10'(WIDTH - 1));
  assign w_last_y  = (r_y == 10'(HEIGHT - 1));
  assign w_timeout = (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    w_next        = r_state;
    o_layer_valid = 1'b0;
    o_layer_tick  = 1'b0;
    o_pix_ack     = 1'b0;
    o_wr_en       = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_next = S_REQ;
      S_REQ: begin
        o_layer_valid = i_layer_ready;
        if (i_layer_ready) w_next = S_WAIT;
      end
      S_WAIT: if (i_pix_valid || w_timeout) w_next = S_WRITE;
      S_WRITE: begin
        o_pix_ack = 1'b1;
        o_wr_en   = 1'b1;
        w_next    = (w_last_x && w_last_y) ? S_TICK : S_REQ;
      end
      S_TICK: begin
        o_layer_valid = i_layer_ready;
        o_layer_tick  = i_layer_ready;
        if (i_layer_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_addr        <= '0;
      r_to_cnt      <= '0;
      r_wr_data     <= '0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
          end
        end
        S_REQ: if (i_layer_ready) r_to_cnt <= '0;
        S_WAIT: begin
          // A response in the final timeout cycle still wins over the abandon path.
          if (i_pix_valid) begin
            r_wr_data <= blend_rgb({i_pix_r, i_pix_g, i_pix_b, i_pix_a});
          end else if (w_timeout) begin
            r_wr_data     <= blend_rgb({BG_COLOR, 8'h00});
            r_timeout_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        S_WRITE: begin
          r_addr <= r_addr + ADDR_W'(1);
          if (w_last_x) begin
            r_x <= '0;
            r_y <= w_last_y ? 10'd0 : r_y + 10'd1;
          end else begin
            r_x <= r_x + 10'd1;
          end
        end
        S_TICK: begin
          if (i_layer_ready) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_done        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_layer_x     = r_x;
  assign o_layer_y     = r_y;
  assign o_wr_addr     = r_addr;
  assign o_wr_data     = r_wr_data;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = r_done;
  assign o_timeout_err = r_timeout_err;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_panel_scan.sv
// tb/tb_panel_scan.sv - scoreboard bench for panel_scan with a behavioural pixel layer
module tb_panel_scan;
  localparam int          W  = 4;
  localparam int          H  = 2;
  localparam int          TO = 15;
  localparam logic [23:0] BG = 24'h204080;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        layer_ready = 1'b1;
  logic        pix_valid = 1'b0;
  logic [7:0]  pix_r = '0;
  logic [7:0]  pix_g = '0;
  logic [7:0]  pix_b = '0;
  logic [7:0]  pix_a = '0;
  logic        layer_valid, layer_tick, pix_ack, wr_en, busy, done, timeout_err;
  logic [9:0]  layer_x, layer_y;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  panel_scan #(.WIDTH(W), .HEIGHT(H), .ADDR_W(3), .TIMEOUT(TO), .BG_COLOR(BG)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_layer_ready(layer_ready),
    .o_layer_valid(layer_valid), .o_layer_tick(layer_tick),
    .o_layer_x(layer_x), .o_layer_y(layer_y),
    .i_pix_valid(pix_valid), .i_pix_r(pix_r), .i_pix_g(pix_g), .i_pix_b(pix_b), .i_pix_a(pix_a),
    .o_pix_ack(pix_ack), .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .o_busy(busy), .o_done(done), .o_timeout_err(timeout_err), .o_frame_count(frame_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [7:0] ref_blend(input int c, input int b, input int a);
    int s;
    s = (c * a + b * (255 - a) + 255) / 256;
    return 8'(s);
  endfunction

  // layer configuration and scoreboard
  int          mode = 0;
  int          no_resp_addr = -1;
  bit          stall_en = 1'b0;
  bit          stalling = 1'b0;
  int          stall_left = 0;
  logic [31:0] exp_q[$];
  int          n_writes = 0;
  int          n_ticks = 0;
  int          n_dones = 0;
  logic [15:0] exp_fc = '0;

  logic        pend = 1'b0;
  logic        ack_prev = 1'b0;
  logic [9:0]  px = '0;
  logic [9:0]  py = '0;
  logic [31:0] e;
  logic [23:0] ex;
  int          a_i;

  always @(posedge clk) begin
    #1;
    if (reset) begin
      pix_valid = 1'b0;
      pend      = 1'b0;
      ack_prev  = 1'b0;
      exp_q.delete();
    end else begin
      if (wr_en) begin
        n_writes++;
        check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[26:24]));
          check("wr_data", 32'(wr_data), 32'(e[23:0]));
        end
        check("done_wr_excl", 32'(done), 32'd0);
      end
      if (done) n_dones++;
      if (layer_valid && layer_tick) n_ticks++;

      if (stall_en && wr_en && wr_addr == 3'(W + 1)) begin
        layer_ready = 1'b0;
        stall_left  = 5;
        stalling    = 1'b1;
      end else if (stalling) begin
        if (stall_left > 0) begin
          check("stall_valid", 32'(layer_valid), 32'd0);
          check("stall_busy", 32'(busy), 32'd1);
          check("stall_wr", 32'(wr_en), 32'd0);
          stall_left--;
        end else begin
          layer_ready = 1'b1;
          #1;
          check("stall_release_valid", 32'(layer_valid), 32'd1);
          check("stall_release_x", 32'(layer_x), 32'd2);
          check("stall_release_y", 32'(layer_y), 32'd1);
          stalling = 1'b0;
          stall_en = 1'b0;
        end
      end

      if (ack_prev) pix_valid = 1'b0;
      ack_prev = pix_ack;
      if (pend) begin
        pend = 1'b0;
        a_i  = int'(py) * W + int'(px);
        if (a_i == no_resp_addr) begin
          exp_q.push_back({5'd0, 3'(a_i), BG});
        end else begin
          case (mode)
            0: begin
              pix_r = 8'(px); pix_g = 8'(py); pix_b = 8'h55; pix_a = 8'hFF;
              ex = {8'(px), 8'(py), 8'h55};
            end
            1: begin
              pix_r = 8'hFF; pix_g = 8'h00; pix_b = 8'h80; pix_a = 8'h80;
              ex = {ref_blend(255, 32, 128), ref_blend(0, 64, 128), ref_blend(128, 128, 128)};
            end
            default: begin
              pix_r = 8'(a_i * 16 + 3); pix_g = 8'(py); pix_b = 8'hAA; pix_a = 8'h00;
              ex = BG;
            end
          endcase
          pix_valid = 1'b1;
          exp_q.push_back({5'd0, 3'(a_i), ex});
        end
      end
      if (layer_valid && !layer_tick) begin
        pend = 1'b1;
        px   = layer_x;
        py   = layer_y;
      end
    end
  end

  task automatic reset_checks();
    check("rst_layer_valid", 32'(layer_valid), 32'd0);
    check("rst_layer_tick", 32'(layer_tick), 32'd0);
    check("rst_pix_ack", 32'(pix_ack), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_layer_xy", 32'({layer_x, layer_y}), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
  endtask

  task automatic run_frame(input bit mid_start, output int lat);
    int n;
    int w0;
    int t0;
    int d0;
    w0 = n_writes; t0 = n_ticks; d0 = n_dones;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (mid_start && n == 10) begin
        check("mid_start_busy", 32'(busy), 32'd1);
        start = 1'b1;
      end
      if (n == 11) start = 1'b0;
    end
    check("frame_done_seen", 32'(done), 32'd1);
    lat = n + 1;
    exp_fc = exp_fc + 16'd1;
    check("frame_count", 32'(frame_count), 32'(exp_fc));
    check("frame_writes", 32'(n_writes - w0), 32'(W * H));
    check("frame_ticks", 32'(n_ticks - t0), 32'd1);
    check("frame_sb_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    check("frame_dones", 32'(n_dones - d0), 32'd1);
  endtask

  initial begin
    int lat;
    int n;
    int w0;
    int d0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks();
    reset = 1'b0;
    @(posedge clk); #1;

    mode = 0;
    run_frame(1'b0, lat);
    check("latency_plain", 32'(lat), 32'(3 * W * H + 2));
    check("terr_clean", 32'(timeout_err), 32'd0);

    mode = 1; stall_en = 1'b1;
    run_frame(1'b0, lat);
    check("latency_stall", 32'(lat), 32'(3 * W * H + 2 + 5));

    mode = 0; no_resp_addr = 3;
    run_frame(1'b0, lat);
    check("latency_timeout", 32'(lat), 32'(3 * W * H + 2 + TO - 1));
    check("terr_set", 32'(timeout_err), 32'd1);

    mode = 2; no_resp_addr = -1;
    run_frame(1'b0, lat);
    check("terr_sticky", 32'(timeout_err), 32'd1);

    mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(layer_valid && layer_x == 10'd1 && layer_y == 10'd1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("p5_req_seen", 32'(layer_valid), 32'd1);
    @(posedge clk); #1;
    check("p5_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset_checks();
    exp_fc = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_frame(1'b0, lat);
    check("latency_after_reset", 32'(lat), 32'(3 * W * H + 2));

    force dut.r_frame_count = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_frame_count;
    exp_fc = 16'hFFFF;
    d0 = n_dones; w0 = n_writes;
    run_frame(1'b1, lat);
    repeat (40) begin @(posedge clk); #1; end
    check("mid_start_single_done", 32'(n_dones - d0), 32'd1);
    check("mid_start_no_extra_writes", 32'(n_writes - w0), 32'(W * H));
    check("idle_after_frame", 32'(busy), 32'd0);
    check("wrap_count", 32'(frame_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
